// File: rtl/cpu_controller_ws.sv
// Phase sequencer for the RISC CPU: walks a 9-state instruction cycle and decodes
// the datapath strobes from the registered state and latched opcode.
module cpu_controller_ws #(
  parameter int OP_CODE_WIDTH = 3,
  parameter int CNT_WIDTH     = 16,
  parameter int WAIT_EN       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     is_zero,
  input  logic [OP_CODE_WIDTH-1:0] op_code,
  input  logic                     mem_ready,
  input  logic                     resume,
  output logic                     sel,
  output logic                     rd,
  output logic                     ld_ir,
  output logic                     halt,
  output logic                     inc_pc,
  output logic                     ld_ac,
  output logic                     ld_pc,
  output logic                     wr,
  output logic                     data_e,
  output logic                     illegal,
  output logic [3:0]               phase,
  output logic [CNT_WIDTH-1:0]     inst_count
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  localparam logic [OP_CODE_WIDTH-1:0] OP_HLT = OP_CODE_WIDTH'(0);
  localparam logic [OP_CODE_WIDTH-1:0] OP_SKZ = OP_CODE_WIDTH'(1);
  localparam logic [OP_CODE_WIDTH-1:0] OP_ADD = OP_CODE_WIDTH'(2);
  localparam logic [OP_CODE_WIDTH-1:0] OP_AND = OP_CODE_WIDTH'(3);
  localparam logic [OP_CODE_WIDTH-1:0] OP_XOR = OP_CODE_WIDTH'(4);
  localparam logic [OP_CODE_WIDTH-1:0] OP_LDA = OP_CODE_WIDTH'(5);
  localparam logic [OP_CODE_WIDTH-1:0] OP_STO = OP_CODE_WIDTH'(6);
  localparam logic [OP_CODE_WIDTH-1:0] OP_JMP = OP_CODE_WIDTH'(7);

  state_e                   state_q, state_d;
  logic [OP_CODE_WIDTH-1:0] op_q;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     memGo;
  logic                     isRdop;
  logic                     isSto;
  logic                     isIllegal;

  // With wait states disabled the memory is assumed to answer in one cycle.
  assign memGo     = (WAIT_EN == 0) ? 1'b1 : mem_ready;
  assign isRdop    = (op_q == OP_ADD) || (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_LDA);
  assign isSto     = (op_q == OP_STO);
  assign isIllegal = (op_q > OP_JMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INST_ADDR;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE) begin
        op_q <= op_code;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = memGo ? INST_LOAD : INST_FETCH;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (op_q == OP_HLT) ? HALTED : OP_FETCH;
      HALTED:     state_d = resume ? OP_FETCH : HALTED;
      OP_FETCH:   state_d = (isRdop && !memGo) ? OP_FETCH : ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = (isSto && !memGo) ? STORE : INST_ADDR;
      default:    state_d = INST_ADDR;
    endcase
  end

  // An instruction retires on the edge that leaves STORE; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == STORE) && (state_d == INST_ADDR) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    sel     = 1'b0;
    rd      = 1'b0;
    ld_ir   = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    ld_ac   = 1'b0;
    ld_pc   = 1'b0;
    wr      = 1'b0;
    data_e  = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      INST_ADDR: sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc  = 1'b1;
        illegal = isIllegal;
      end
      HALTED:   halt = 1'b1;
      OP_FETCH: rd = isRdop;
      ALU_OP: begin
        rd     = isRdop;
        inc_pc = (op_q == OP_SKZ) && is_zero;
        ld_pc  = (op_q == OP_JMP);
        data_e = isSto;
      end
      STORE: begin
        rd     = isRdop;
        ld_ac  = isRdop;
        ld_pc  = (op_q == OP_JMP);
        wr     = isSto;
        data_e = isSto;
      end
      default: ;
    endcase
  end

  assign phase      = state_q;
  assign inst_count = cnt_q;

endmodule
